turn_controller: RTL

TURN_CONTROLLER -- requirements
Module: turn_controller

---
 rtl/turn_controller.sv | 98 +++++++++
 1 files changed

// File: rtl/turn_controller.sv
// turn_controller: two-player artillery turn sequencer (aim, charge, launch, flight, settle, game over).
module turn_controller #(
    parameter int unsigned CHARGE_TICK    = 3_000_000,
    parameter int unsigned SETTLE_CYCLES  = 60_000_000,
    parameter int unsigned FLIGHT_TIMEOUT = 600_000_000
) (
    input  logic       clk60MHz,
    input  logic       rst,
    input  logic       throw_btn,
    input  logic       end_throw,
    input  logic [6:0] hp_player1,
    input  logic [6:0] hp_player2,
    output logic       throw_flag,
    output logic       turn,
    output logic [1:0] current_player,
    output logic [4:0] speed,
    output logic       game_over,
    output logic [1:0] winner
);
    localparam logic [1:0] NONE = 2'b00, PLAYER_1 = 2'b01, PLAYER_2 = 2'b10;
    typedef enum logic [2:0] {AIM, CHARGE, LAUNCH, FLIGHT, SETTLE, GAME_OVER} state_t;
    state_t state, state_n;
    logic [31:0] cnt, cnt_n;
    logic btn_prev, turn_n, flag_n, go_n, p1_dead, p2_dead;
    logic [1:0] cp_n, win_n;
    logic [4:0] speed_n;
    assign p1_dead = hp_player1 == 7'd0 || hp_player1 > 7'd100;
    assign p2_dead = hp_player2 == 7'd0 || hp_player2 > 7'd100;
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 32'd1;
        speed_n = speed;
        turn_n  = turn;
        cp_n    = current_player;
        go_n    = game_over;
        win_n   = winner;
        case (state)
            AIM: begin
                cnt_n = '0;
                if (throw_btn && !btn_prev) begin
                    state_n = CHARGE;
                    speed_n = 5'd1;
                end
            end
            CHARGE: begin
                if (!throw_btn) state_n = LAUNCH;
                else if (cnt == 32'(CHARGE_TICK - 1)) begin
                    cnt_n   = '0;
                    speed_n = speed == 5'd31 ? speed : speed + 5'd1;
                end
            end
            LAUNCH: state_n = FLIGHT;
            FLIGHT: if (end_throw || cnt == 32'(FLIGHT_TIMEOUT - 1)) state_n = SETTLE;
            SETTLE: begin
                if (cnt == 32'(SETTLE_CYCLES - 1)) begin
                    speed_n = '0;
                    if (p1_dead || p2_dead) begin
                        state_n = GAME_OVER;
                        go_n    = 1'b1;
                        cp_n    = NONE;
                        win_n   = (p1_dead && p2_dead) ? current_player : p1_dead ? PLAYER_2 : PLAYER_1;
                    end else begin
                        state_n = AIM;
                        turn_n  = !turn;
                        cp_n    = current_player == PLAYER_1 ? PLAYER_2 : PLAYER_1;
                    end
                end
            end
            GAME_OVER: cnt_n = '0;
            default: state_n = AIM;
        endcase
        if (state_n != state) cnt_n = '0;
        flag_n = state_n == LAUNCH;
    end
    always_ff @(posedge clk60MHz) begin
        if (rst) begin
            state          <= AIM;
            cnt            <= '0;
            btn_prev       <= 1'b1;
            throw_flag     <= 1'b0;
            turn           <= 1'b0;
            current_player <= PLAYER_1;
            speed          <= '0;
            game_over      <= 1'b0;
            winner         <= NONE;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            btn_prev       <= throw_btn;
            throw_flag     <= flag_n;
            turn           <= turn_n;
            current_player <= cp_n;
            speed          <= speed_n;
            game_over      <= go_n;
            winner         <= win_n;
        end
    end
endmodule
